// File: rtl/cic_comp_fir_if.sv
// Sample/result bus of the CIC compensation FIR, with a debug view of the FSM state.
interface cic_comp_fir_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 18
);
  // din_valid is a one-cycle strobe with no ready: a strobe seen while busy=1 is
  // discarded and latches ovf. dout_valid is a one-cycle strobe; dout holds between strobes.
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         din_valid;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         busy;
  logic                         ovf;
  logic [1:0]                   fsm_state;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, busy, ovf, fsm_state
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, busy, ovf, fsm_state
  );
endinterface

// File: rtl/cic_comp_fir.sv
// Time-multiplexed CIC droop-compensation FIR with optional decimate-by-2 and scale/saturate.
// Define CIC_COMP_FIR_ROUND_EN for round-half-up before the shift; otherwise the shift truncates.
module cic_comp_fir #(
  parameter int DIN_WIDTH  = 32,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 21,
  parameter int DEC        = 2,
  parameter int SHIFT      = 20,
  parameter int DOUT_WIDTH = 18,
  // Coefficient ROM contents, entry 0 (multiplies newest sample) in the least significant slot.
  parameter logic [TAPS*COEF_WIDTH-1:0] COEFS = {
    -18'sd120, 18'sd310, -18'sd620, 18'sd1020, -18'sd1540, 18'sd2160, -18'sd2950,
    18'sd4020, -18'sd5700, 18'sd9500, 18'sd120000, 18'sd9500, -18'sd5700, 18'sd4020,
    -18'sd2950, 18'sd2160, -18'sd1540, 18'sd1020, -18'sd620, 18'sd310, -18'sd120
  }
) (
  input  logic          clk,
  input  logic          rst,
  cic_comp_fir_if.slave bus
);

  localparam int ACC_WIDTH  = DIN_WIDTH + COEF_WIDTH + $clog2(TAPS);
  localparam int PROD_WIDTH = DIN_WIDTH + COEF_WIDTH;
  localparam int PTR_W      = $clog2(TAPS);
  localparam int FILL_W     = $clog2(TAPS + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(TAPS - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS);

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH + 2 - DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

`ifdef CIC_COMP_FIR_ROUND_EN
  localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << RND_BIT) : {(ACC_WIDTH + 1){1'b0}};
`else
  localparam logic signed [ACC_WIDTH:0] RND = {(ACC_WIDTH + 1){1'b0}};
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_SCALE = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [DIN_WIDTH-1:0]  ram [TAPS];
  logic signed [COEF_WIDTH-1:0] coef_rom [TAPS];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt, tap_cnt;
  logic [FILL_W-1:0] fill, next_tap;
  logic              dec_phase;

  logic signed [DIN_WIDTH-1:0]  x_rd;
  logic signed [COEF_WIDTH-1:0] h_rd;
  logic                         tap_live;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, acc;
  logic signed [ACC_WIDTH:0]    acc_rnd, acc_shr;
  logic signed [DOUT_WIDTH-1:0] sat_c, sat_q;

  logic accept, trigger;
  logic busy_c, mac_en, scale_en, out_en;

  for (genvar g = 0; g < TAPS; g++) begin : g_rom
    assign coef_rom[g] = COEFS[g*COEF_WIDTH +: COEF_WIDTH];
  end

  assign accept  = bus.din_valid && !busy_c;
  assign trigger = accept && ((DEC == 1) || dec_phase);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_MAC;
      S_MAC:   if (tap_cnt == LAST_PTR) state_nxt = S_SCALE;
      S_SCALE: state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_c   = 1'b0;
    mac_en   = 1'b0;
    scale_en = 1'b0;
    out_en   = 1'b0;
    case (state)
      S_MAC:   begin busy_c = 1'b1; mac_en   = 1'b1; end
      S_SCALE: begin busy_c = 1'b1; scale_en = 1'b1; end
      S_OUT:   begin busy_c = 1'b1; out_en   = 1'b1; end
      default: ;
    endcase
  end

  assign bus.busy      = busy_c;
  assign bus.fsm_state = state;

  // Walk the delay line backwards from the newest sample, one tap per clock.
  assign rd_ptr_nxt = (rd_ptr == '0) ? LAST_PTR : rd_ptr - PTR_W'(1);
  assign next_tap   = FILL_W'(tap_cnt) + FILL_W'(1);

  // Taps beyond the samples received since reset read stale RAM, so they are forced to zero.
  assign prod     = x_rd * h_rd;
  assign prod_ext = tap_live ? {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod} : '0;

  always_comb begin
    acc_rnd = {acc[ACC_WIDTH-1], acc} + RND;
    acc_shr = acc_rnd >>> SHIFT;
    if (acc_shr > SAT_MAX)      sat_c = SAT_MAX[DOUT_WIDTH-1:0];
    else if (acc_shr < SAT_MIN) sat_c = SAT_MIN[DOUT_WIDTH-1:0];
    else                        sat_c = acc_shr[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) ram[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tap_cnt        <= '0;
      fill           <= '0;
      dec_phase      <= 1'b0;
      x_rd           <= '0;
      h_rd           <= '0;
      tap_live       <= 1'b0;
      acc            <= '0;
      sat_q          <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.ovf        <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      if (bus.din_valid && busy_c) bus.ovf <= 1'b1;

      if (accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
        if (DEC == 2) dec_phase <= ~dec_phase;
      end

      // The newest sample is still being written, so tap 0 takes it straight from din.
      if (trigger) begin
        acc      <= '0;
        tap_cnt  <= '0;
        rd_ptr   <= wr_ptr;
        x_rd     <= bus.din;
        h_rd     <= coef_rom[0];
        tap_live <= 1'b1;
      end

      if (mac_en) begin
        acc     <= acc + prod_ext;
        tap_cnt <= tap_cnt + PTR_W'(1);
        if (tap_cnt != LAST_PTR) begin
          rd_ptr   <= rd_ptr_nxt;
          x_rd     <= ram[rd_ptr_nxt];
          h_rd     <= coef_rom[tap_cnt + PTR_W'(1)];
          tap_live <= next_tap < fill;
        end
      end

      if (scale_en) sat_q <= sat_c;

      if (out_en) begin
        bus.dout       <= sat_q;
        bus.dout_valid <= 1'b1;
      end
    end
  end

endmodule
